// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier: buffers a feature vector, then walks a
// programmable node table one node per cycle through a single shared comparator.
module dtree_seq_engine #(
    parameter int unsigned N_FEAT    = 64,
    parameter int unsigned NODES     = 64,
    parameter int unsigned FIDX_W    = 6,
    parameter int unsigned CLASS_W   = 5,
    parameter int unsigned MAX_DEPTH = 16,
    localparam int unsigned NODE_AW  = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int unsigned NODE_W   = 1 + FIDX_W + 3 + 8 + 2 * NODE_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [NODE_W-1:0]  cfg_wdata,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned CNT_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {LOAD, WALK, DONE} state_t;

    typedef struct packed {
        logic               leaf;
        logic [FIDX_W-1:0]  fidx;
        logic [2:0]         shift;
        logic [7:0]         thr;
        logic [NODE_AW-1:0] left;
        logic [NODE_AW-1:0] right;
    } node_t;

    node_t              table_q [NODES];
    logic [7:0]         feat    [N_FEAT];

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [NODE_AW-1:0] ptr, ptr_nx;
    logic [DEPTH_W-1:0] depth, depth_nx;
    logic [CLASS_W-1:0] class_nx;
    logic               err_nx;
    logic               busy_nx;
    logic               in_fire;
    node_t              cur;
    logic [7:0]         fsel;
    logic [7:0]         v;

    assign in_fire = in_valid & in_ready;
    assign cur     = table_q[ptr];

    // Feature select; an index beyond the buffer naturally reads as zero.
    always_comb begin
        fsel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (cur.fidx == FIDX_W'(i)) fsel = feat[i];
        end
        v = fsel >> cur.shift;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        depth_nx = depth;
        class_nx = out_class;
        err_nx   = out_err;
        case (state)
            LOAD: begin
                if (in_fire) begin
                    if (cnt == CNT_W'(N_FEAT - 1)) begin
                        cnt_nx   = '0;
                        ptr_nx   = '0;
                        depth_nx = '0;
                        state_nx = WALK;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            WALK: begin
                if (cur.leaf) begin
                    class_nx = CLASS_W'(cur);
                    err_nx   = 1'b0;
                    state_nx = DONE;
                end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
                    class_nx = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    ptr_nx   = (v <= cur.thr) ? cur.left : cur.right;
                    depth_nx = depth + DEPTH_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
        busy_nx = (state_nx != LOAD) || (cnt_nx != '0);
    end

    // Handshake and status outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            ptr       <= '0;
            depth     <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ptr       <= ptr_nx;
            depth     <= depth_nx;
            out_class <= class_nx;
            out_err   <= err_nx;
            in_ready  <= (state_nx == LOAD);
            out_valid <= (state_nx == DONE);
            busy      <= busy_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) table_q[i] <= '0;
        end else if (cfg_we && !busy) begin
            table_q[cfg_addr] <= node_t'(cfg_wdata);
        end
    end

    // Feature buffer is intentionally unreset; each full load overwrites it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < N_FEAT; i++) begin
                if (cnt == CNT_W'(i)) feat[i] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_dtree_seq_engine.sv
// Scoreboard bench for dtree_seq_engine with a 4-feature, 3-node tree.
module tb_dtree_seq_engine;

    localparam int unsigned NODE_AW = 6;
    localparam int unsigned NODE_W  = 30;
    localparam logic [NODE_W-1:0] NODE0 = {1'b0, 6'd2, 3'd5, 8'd3, 6'd1, 6'd2};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [NODE_AW-1:0] cfg_addr = '0;
    logic [NODE_W-1:0]  cfg_wdata = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [4:0]         out_class;
    logic               out_err;
    logic               busy;

    typedef struct {
        logic [4:0] cls;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    dtree_seq_engine #(.N_FEAT(4)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NODE_W-1:0] leaf(input logic [4:0] cls);
        return {1'b1, 29'(cls)};
    endfunction

    function automatic exp_t mk(input logic [4:0] cls, input logic err, input int lat);
        exp_t e;
        e.cls = cls; e.err = err; e.lat = lat;
        return e;
    endfunction

    task automatic cfg_write(input logic [NODE_AW-1:0] a, input logic [NODE_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic program_tree();
        cfg_write(6'd0, NODE0);
        cfg_write(6'd1, leaf(5'd13));
        cfg_write(6'd2, leaf(5'd2));
    endtask

    // Streams four features; returns #1 after the last handshake edge (T).
    task automatic drive_feats(input logic [7:0] f0, f1, f2, f3);
        logic [7:0] f [4];
        f = '{f0, f1, f2, f3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = f[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Latency is counted in cycles after T until out_valid is seen; bounded.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            cfg_we = 1'b0;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 5'd0 || out_err !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: rdy=%b vld=%b cls=%0d err=%b busy=%b expected 1 0 0 0 0",
                     in_ready, out_valid, out_class, out_err, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_unprogrammed_abort();
        int lat;
        exp_t e;
        sb.push_back(mk(5'd0, 1'b1, 18));
        drive_feats(8'h11, 8'h22, 8'h33, 8'h44);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL walk_status: rdy=%b busy=%b expected 0 1", in_ready, busy);
        end
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL abort: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        release_result();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_leaf_paths();
        int lat;
        exp_t e;
        logic [7:0] f2v [2];
        f2v = '{8'h60, 8'h80};
        program_tree();
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk((k == 0) ? 5'd13 : 5'd2, 1'b0, 3));
            drive_feats(8'h00, 8'h00, f2v[k], 8'h00);
            wait_result(lat);
            e = sb.pop_front();
            n_cmp++;
            if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL leaf_%0d: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                         k, out_class, out_err, lat, e.cls, e.err, e.lat);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        sb.push_back(mk(5'd13, 1'b0, 3));
        drive_feats(8'h00, 8'h00, 8'h60, 8'h00);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_result: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_class !== e.cls || out_err !== e.err || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: vld=%b cls=%0d err=%b rdy=%b expected 1 %0d %b 0",
                         c, out_valid, out_class, out_err, in_ready, e.cls, e.err);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b busy=%b vld=%b expected 1 0 0", in_ready, busy, out_valid);
        end
        sb.push_back(mk(5'd2, 1'b0, 3));
        drive_feats(8'h00, 8'h00, 8'h80, 8'h00);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL bp_next_load: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        release_result();
    endtask

    task automatic test_cfg_busy();
        int lat;
        exp_t e;
        sb.push_back(mk(5'd13, 1'b0, 3));
        drive_feats(8'h00, 8'h00, 8'h60, 8'h00);
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = leaf(5'd7);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL cfg_in_walk: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        release_result();
        cfg_write(6'd1, leaf(5'd7));
        sb.push_back(mk(5'd7, 1'b0, 3));
        drive_feats(8'h00, 8'h00, 8'h60, 8'h00);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL cfg_in_load: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        release_result();
    endtask

    task automatic test_reset_midload();
        int lat;
        exp_t e;
        in_valid = 1'b1;
        in_data  = 8'h05;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL partial_busy: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midload_reset: rdy=%b busy=%b expected 1 0", in_ready, busy);
        end
        sb.push_back(mk(5'd0, 1'b1, 18));
        drive_feats(8'h00, 8'h00, 8'h60, 8'h00);
        wait_result(lat);
        e = sb.pop_front();
        n_cmp++;
        if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
            n_err++;
            $display("FAIL midload_abort: cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                     out_class, out_err, lat, e.cls, e.err, e.lat);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        logic [7:0] f2;
        program_tree();
        for (int k = 0; k < 6; k++) begin
            f2 = 8'($urandom_range(0, 255));
            sb.push_back(mk(((f2 >> 5) <= 8'd3) ? 5'd13 : 5'd2, 1'b0, 3));
            drive_feats(8'($urandom), 8'($urandom), f2, 8'($urandom));
            wait_result(lat);
            e = sb.pop_front();
            n_cmp++;
            if (out_class !== e.cls || out_err !== e.err || lat != e.lat) begin
                n_err++;
                $display("FAIL b2b_%0d (f2=%h): cls=%0d err=%b lat=%0d expected cls=%0d err=%b lat=%0d",
                         k, f2, out_class, out_err, lat, e.cls, e.err, e.lat);
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_unprogrammed_abort();
        test_leaf_paths();
        test_backpressure();
        test_cfg_busy();
        test_reset_midload();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dtree_seq_engine.md
# dtree_seq_engine

Sequential, table-driven decision-tree classifier for the printed-tree flow. It replaces a fully unrolled comparator tree with one shared comparator, which is time-multiplexed over a programmable node table, one node per cycle. Features stream in over a valid/ready port, the tree is walked from node 0 to a leaf, and the leaf class is returned on a valid/ready result port. A host or ROM loader programs the node table through a write-only configuration port.

## Interface
- N_FEAT, 64 — number of 8-bit features buffered per inference (1..64)
- NODES, 64 — node-table depth; NODE_AW = clog2(NODES)
- FIDX_W, 6 — feature-index field width
- CLASS_W, 5 — class width
- MAX_DEPTH, 16 — maximum node visits per inference before abort
- NODE_W, derived — 1+FIDX_W+3+8+2*NODE_AW (30 at defaults)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  NODE_AW  node index
- cfg_wdata  in  NODE_W  fields, MSB→LSB: {leaf, fidx, shift[2:0], thr[7:0], left, right}; for a leaf node, class = cfg_wdata[CLASS_W-1:0]
- in_valid / in_ready  in / out  1  feature handshake
- in_data  in  8  feature value; features arrive in index order 0..N_FEAT-1
- out_valid / out_ready  out / in  1  result handshake
- out_class  out  CLASS_W  predicted class
- out_err  out  1  depth-abort flag, qualified by out_valid
- busy  out  1  high in WALK or DONE, or while the feature count is nonzero

## Operation
- FSM states: LOAD, WALK, DONE. Reset enters LOAD with feature count 0 and node pointer 0.
- LOAD:
  - in_ready = 1.
  - Each handshake stores in_data at feat[cnt] and increments cnt.
  - The handshake at cnt = N_FEAT-1 clears cnt, sets ptr = 0 and depth = 0, then moves to WALK.
- WALK: one node is evaluated per cycle from a combinational read of node[ptr].
  - Leaf node: out_class = class field, out_err = 0, go to DONE.
  - Internal node: compute v = feat[fidx] >> shift. If fidx ≥ N_FEAT, v = 0. If v ≤ thr (unsigned, 8-bit), ptr ← left, else ptr ← right. depth increments.
  - Abort: when depth = MAX_DEPTH on an internal node, set out_class = 0 and out_err = 1, then go to DONE.
- DONE:
  - out_valid = 1; out_class and out_err are held stable.
  - On out_ready, go to LOAD.
- Node table:
  - Written only when busy = 0. cfg_we while busy = 1 is dropped silently.
  - A write and an in_valid handshake in the same cycle are both accepted.
  - The table resets to all-zero. The all-zero node 0 is internal with left = right = 0, so an unprogrammed table always ends in a depth abort.
- Feature buffer is not cleared on reset. Stale values are overwritten by every complete load.
- Reset in any state: returns to LOAD with cnt = 0 and the table zeroed. A partial feature load is discarded.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_class = 0, out_err = 0, busy = 0.
- Let T be the cycle of the last feature handshake. The root is evaluated at T+1.
- A leaf at depth d (root = 0) is evaluated at T+1+d, and out_valid rises at T+2+d.
- A depth abort raises out_valid at T+2+MAX_DEPTH.
- in_ready = 0 from T+1 until the cycle after the out_valid & out_ready handshake. No feature is accepted in the handshake cycle itself.
- out_valid stays high with stable data under back-pressure for any number of cycles.
- Throughput: N_FEAT + d + 2 cycles per inference, with out_ready held high.

## Test plan
- Table setup:
  - node0 = {0, fidx 2, shift 5, thr 3, L 1, R 2}
  - node1 = leaf class 13
  - node2 = leaf class 2
  - N_FEAT = 4
- Stream features {0, 0, 0x60, 0}: 0x60>>5 = 3 ≤ 3, so out_class = 13 and out_err = 0, with out_valid at T+3.
- Same table, stream {0, 0, 0x80, 0}: 4 > 3, so out_class = 2 at T+3.
- After reset with no cfg writes, stream any 4 features: out_err = 1 and out_class = 0 at T+2+16.
- Hold out_ready = 0 for 10 cycles in DONE while driving in_valid = 1: out_valid and out_class stay stable, in_ready = 0, and no feature is consumed. Release, and the next load starts with feat[0].
- Pulse cfg_we to node1 with class 7 during WALK, then rerun the first stream: result is still 13. The same write issued in LOAD with cnt = 0 gives a result of 7 on the next run.
- Assert rst after 2 of 4 features are loaded: in_ready = 1, busy = 0. The next 4 features form a complete fresh inference, and the table is zeroed, so that inference ends in a depth abort.
